cp0_exc_unit: RTL and testbench

//   Coprocessor-0 for the pipelined MIPS core; sits beside the M stage.

---
 rtl/cp0_pkg.sv | 39 +++
 rtl/cp0_req_arbiter.sv | 32 +++
 rtl/cp0_exc_unit.sv | 129 ++++++++++++
 tb/tb_cp0_exc_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes, field positions
// and the victim-PC to EPC helper.
package cp0_pkg;

    localparam logic [31:0] PRID_DEFAULT    = 32'h2022_0202;
    localparam int          HWINT_W_DEFAULT = 6;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LO      = 10;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_IP_LO   = 10;
    localparam int CAUSE_BD_BIT  = 31;

    // A delay-slot victim must restart at its branch, one word earlier.
    function automatic logic [31:0] victim_epc(input logic [31:0] vpc, input logic bd);
        logic [31:0] epc_v;
        if (bd) begin
            epc_v = vpc - 32'd4;
        end else begin
            epc_v = vpc;
        end
        return epc_v;
    endfunction

endpackage

// File: rtl/cp0_req_arbiter.sv
// Combinational interrupt/exception arbitration; interrupts take priority
// and everything is masked while EXL is set.
module cp0_req_arbiter
    import cp0_pkg::*;
#(
    parameter int HWINT_W = HWINT_W_DEFAULT
) (
    input  logic [HWINT_W-1:0] hw_int,
    input  logic [HWINT_W-1:0] sr_im,
    input  logic               sr_ie,
    input  logic               sr_exl,
    input  logic [4:0]         exc_code_in,
    output logic               req,
    output logic [4:0]         exc_code
);

    logic int_req_s;
    logic exc_req_s;

    // Request qualification and cause selection.
    always_comb begin
        int_req_s = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
        exc_req_s = (exc_code_in != 5'd0) & ~sr_exl;
        req       = int_req_s | exc_req_s;
        if (int_req_s) begin
            exc_code = EXC_INT;
        end else begin
            exc_code = exc_code_in;
        end
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 beside the M stage: SR/Cause/EPC/PRId storage, exception
// entry, MTC0 writes, ERET EXL clear and the forwarded EPC for ERET.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID    = PRID_DEFAULT,
    parameter int          HWINT_W = HWINT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         A1,
    input  logic [4:0]         A2,
    input  logic [31:0]        DIn,
    input  logic               we,
    input  logic [31:0]        VPC,
    input  logic               BDIn,
    input  logic [4:0]         ExcCodeIn,
    input  logic [HWINT_W-1:0] HWInt,
    input  logic               EXLClr,
    output logic               Req,
    output logic [31:0]        EPCOut,
    output logic [31:0]        DOut
);

    logic [HWINT_W-1:0] sr_im_r;
    logic               sr_exl_r;
    logic               sr_ie_r;
    logic               cause_bd_r;
    logic [HWINT_W-1:0] cause_ip_r;
    logic [4:0]         cause_exc_r;
    logic [31:0]        epc_r;

    logic               req_s;
    logic [4:0]         exc_code_s;
    logic               wr_sr_s;
    logic               wr_epc_s;

    cp0_req_arbiter #(.HWINT_W(HWINT_W)) u_arb (
        .hw_int      (HWInt),
        .sr_im       (sr_im_r),
        .sr_ie       (sr_ie_r),
        .sr_exl      (sr_exl_r),
        .exc_code_in (ExcCodeIn),
        .req         (req_s),
        .exc_code    (exc_code_s)
    );

    assign Req      = req_s;
    assign wr_sr_s  = we & (A2 == REG_SR);
    assign wr_epc_s = we & (A2 == REG_EPC);

    // SR: exception entry sets EXL and discards the flushed MTC0; otherwise
    // MTC0 loads the writable fields and ERET clears EXL last.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_r  <= '0;
            sr_exl_r <= 1'b0;
            sr_ie_r  <= 1'b0;
        end else if (req_s) begin
            sr_exl_r <= 1'b1;
        end else begin
            if (wr_sr_s) begin
                sr_im_r <= DIn[SR_IM_LO +: HWINT_W];
                sr_ie_r <= DIn[SR_IE_BIT];
            end
            if (EXLClr) begin
                sr_exl_r <= 1'b0;
            end else if (wr_sr_s) begin
                sr_exl_r <= DIn[SR_EXL_BIT];
            end
        end
    end

    // Cause: IP samples the interrupt lines every cycle; BD/ExcCode on entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            cause_bd_r  <= 1'b0;
            cause_ip_r  <= '0;
            cause_exc_r <= 5'd0;
        end else begin
            cause_ip_r <= HWInt;
            if (req_s) begin
                cause_bd_r  <= BDIn;
                cause_exc_r <= exc_code_s;
            end
        end
    end

    // EPC: victim PC on entry, MTC0 otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            epc_r <= 32'd0;
        end else if (req_s) begin
            epc_r <= victim_epc(VPC, BDIn);
        end else if (wr_epc_s) begin
            epc_r <= DIn;
        end
    end

    // An ERET right behind an MTC0 EPC must see the value being written.
    always_comb begin
        if (wr_epc_s & ~req_s) begin
            EPCOut = DIn;
        end else begin
            EPCOut = epc_r;
        end
    end

    // MFC0 read mux; unimplemented bits and registers read as zero.
    always_comb begin
        DOut = 32'd0;
        case (A1)
            REG_SR: begin
                DOut[SR_IM_LO +: HWINT_W] = sr_im_r;
                DOut[SR_EXL_BIT]          = sr_exl_r;
                DOut[SR_IE_BIT]           = sr_ie_r;
            end
            REG_CAUSE: begin
                DOut[CAUSE_BD_BIT]           = cause_bd_r;
                DOut[CAUSE_IP_LO +: HWINT_W] = cause_ip_r;
                DOut[CAUSE_EXC_LO +: 5]      = cause_exc_r;
            end
            REG_EPC:  DOut = epc_r;
            REG_PRID: DOut = PRID;
            default:  DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: directed scenarios plus randomized
// traffic, all checked against a register-word reference model.
module tb_cp0_exc_unit;

    localparam logic [31:0] PRID_V = 32'h2022_0202;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2, ExcCodeIn;
    logic [31:0] DIn, VPC;
    logic        we, BDIn, EXLClr;
    logic [5:0]  HWInt;
    logic        Req;
    logic [31:0] EPCOut, DOut;

    int errors = 0;
    int checks = 0;

    // reference model: whole architectural register words
    logic [31:0] m_sr, m_cause, m_epc;

    cp0_exc_unit dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .we(we),
        .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .Req(Req), .EPCOut(EPCOut), .DOut(DOut)
    );

    always #5 clk = ~clk;

    function automatic logic m_int_req();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int_req() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_epcout();
        if (we && A2 == 5'd14 && !m_req()) return DIn;
        return m_epc;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID_V;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step();
        logic [31:0] ns, nc, ne;
        logic [4:0]  code;
        ns = m_sr; nc = m_cause; ne = m_epc;
        if (reset) begin
            ns = 32'd0; nc = 32'd0; ne = 32'd0;
        end else begin
            nc = (nc & ~32'h0000_FC00) | (32'(HWInt) << 10);
            if (m_req()) begin
                code = m_int_req() ? 5'd0 : ExcCodeIn;
                ns = ns | 32'h2;
                nc = (nc & ~32'h8000_007C) | (32'(BDIn) << 31) | (32'(code) << 2);
                ne = BDIn ? VPC - 32'd4 : VPC;
            end else begin
                if (we && A2 == 5'd12) ns = DIn & 32'h0000_FC03;
                if (we && A2 == 5'd14) ne = DIn;
                if (EXLClr) ns = ns & ~32'h2;
            end
        end
        m_sr = ns; m_cause = nc; m_epc = ne;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic idle();
        we = 1'b0; A2 = 5'd0; DIn = 32'd0; VPC = 32'd0; BDIn = 1'b0;
        ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0; A1 = 5'd0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++;
        if (Req !== 1'b0) $display("FAIL reset_req: got %b expected 0", Req);
        checks++;
        if (EPCOut !== 32'd0) $display("FAIL reset_epcout: got %h expected 0", EPCOut);
        if (Req !== 1'b0) errors++;
        if (EPCOut !== 32'd0) errors++;
        for (int a = 12; a <= 15; a++) begin
            A1 = a[4:0]; #1;
            checks++;
            if (DOut !== ((a == 15) ? PRID_V : 32'd0)) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected %h", a, DOut, (a == 15) ? PRID_V : 32'd0);
            end
        end
    endtask

    task automatic test_interrupt();
        idle(); we = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
        tick();
        idle(); HWInt = 6'b000001; VPC = 32'h3010;
        #1;
        checks++;
        if (Req !== 1'b1) begin errors++; $display("FAIL int_req: got %b expected 1", Req); end
        tick();
        idle();
        A1 = 5'd14; #1; checks++;
        if (DOut !== 32'h3010) begin errors++; $display("FAIL int_epc: got %h expected 00003010", DOut); end
        A1 = 5'd13; #1; checks++;
        if (DOut !== 32'h0000_0400) begin errors++; $display("FAIL int_cause: got %h expected 00000400", DOut); end
        A1 = 5'd12; #1; checks++;
        if (DOut !== 32'h0000_0403) begin errors++; $display("FAIL int_sr: got %h expected 00000403", DOut); end
        EXLClr = 1'b1;
        tick();
    endtask

    task automatic test_exception_bd();
        idle(); we = 1'b1; A2 = 5'd12; DIn = 32'd0;
        tick();
        idle(); ExcCodeIn = 5'd12; BDIn = 1'b1; VPC = 32'h3024;
        #1; checks++;
        if (Req !== 1'b1) begin errors++; $display("FAIL ov_req: got %b expected 1", Req); end
        tick();
        idle();
        A1 = 5'd14; #1; checks++;
        if (DOut !== 32'h3020) begin errors++; $display("FAIL ov_epc: got %h expected 00003020", DOut); end
        A1 = 5'd13; #1; checks++;
        if (DOut !== 32'h8000_0030) begin errors++; $display("FAIL ov_cause: got %h expected 80000030", DOut); end
        EXLClr = 1'b1;
        tick();
    endtask

    task automatic test_exl_mask();
        idle(); we = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
        tick();
        idle(); ExcCodeIn = 5'd10; VPC = 32'h100;
        tick();
        idle(); HWInt = 6'b100000; ExcCodeIn = 5'd4;
        #1; checks++;
        if (Req !== 1'b0) begin errors++; $display("FAIL exl_mask_req: got %b expected 0", Req); end
        tick();
        ExcCodeIn = 5'd0; EXLClr = 1'b1;
        #1; checks++;
        if (Req !== 1'b0) begin errors++; $display("FAIL exl_clr_req: got %b expected 0", Req); end
        tick();
        EXLClr = 1'b0;
        #1; checks++;
        if (Req !== 1'b1) begin errors++; $display("FAIL exl_unmask_req: got %b expected 1", Req); end
        tick();
        idle(); EXLClr = 1'b1;
        for (int a = 12; a <= 14; a++) begin
            A1 = a[4:0]; #1; checks++;
            if (DOut !== m_read(A1)) begin
                errors++;
                $display("FAIL exl_reg%0d: got %h expected %h", a, DOut, m_read(A1));
            end
        end
        tick();
    endtask

    task automatic test_epc_forward();
        idle(); we = 1'b1; A2 = 5'd14; DIn = 32'h3100; A1 = 5'd14;
        #1; checks++;
        if (EPCOut !== 32'h3100) begin errors++; $display("FAIL fwd_epcout: got %h expected 00003100", EPCOut); end
        checks++;
        if (DOut !== m_epc) begin errors++; $display("FAIL fwd_no_dout_bypass: got %h expected %h", DOut, m_epc); end
        tick();
        idle(); A1 = 5'd14;
        #1; checks++;
        if (DOut !== 32'h3100) begin errors++; $display("FAIL fwd_epc_reg: got %h expected 00003100", DOut); end
        we = 1'b1; A2 = 5'd14; DIn = 32'h5555_0000; ExcCodeIn = 5'd5; VPC = 32'h4000;
        #1; checks++;
        if (EPCOut !== 32'h3100) begin errors++; $display("FAIL fwd_req_epcout: got %h expected 00003100", EPCOut); end
        tick();
        idle(); A1 = 5'd14;
        #1; checks++;
        if (DOut !== 32'h4000) begin errors++; $display("FAIL fwd_req_epc: got %h expected 00004000", DOut); end
        EXLClr = 1'b1;
        tick();
    endtask

    task automatic test_simultaneous();
        idle(); HWInt = 6'b000001; ExcCodeIn = 5'd12; EXLClr = 1'b1; VPC = 32'h2; BDIn = 1'b1;
        we = 1'b1; A2 = 5'd12; DIn = 32'd0;
        #1; checks++;
        if (Req !== 1'b1) begin errors++; $display("FAIL sim_req: got %b expected 1", Req); end
        tick();
        idle();
        A1 = 5'd12; #1; checks++;
        if (DOut !== 32'h0000_FC03) begin errors++; $display("FAIL sim_sr: got %h expected 0000fc03", DOut); end
        A1 = 5'd13; #1; checks++;
        if (DOut !== 32'h8000_0400) begin errors++; $display("FAIL sim_cause: got %h expected 80000400", DOut); end
        A1 = 5'd14; #1; checks++;
        if (DOut !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sim_epc_wrap: got %h expected fffffffe", DOut); end
        we = 1'b1; A2 = 5'd12; DIn = 32'h0000_0403; EXLClr = 1'b1;
        tick();
        idle(); A1 = 5'd12;
        #1; checks++;
        if (DOut !== 32'h0000_0401) begin errors++; $display("FAIL sim_mtc0_eret_sr: got %h expected 00000401", DOut); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            reset     = ($urandom_range(0, 63) == 0);
            we        = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0: A2 = 5'd12;
                1: A2 = 5'd13;
                2: A2 = 5'd14;
                3: A2 = 5'd15;
                default: A2 = 5'($urandom);
            endcase
            DIn       = (r[0]) ? $urandom : ($urandom & 32'h0000_FC03);
            VPC       = $urandom;
            BDIn      = r[1];
            ExcCodeIn = (r[4:2] == 3'd0) ? 5'($urandom) : 5'd0;
            HWInt     = (r[6:5] == 2'd0) ? 6'($urandom) : 6'd0;
            EXLClr    = (r[8:7] == 2'd0);
            A1        = r[9] ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            #1; checks++;
            if (Req !== m_req()) begin
                errors++; $display("FAIL rnd_req[%0d]: got %b expected %b", i, Req, m_req());
            end
            checks++;
            if (EPCOut !== m_epcout()) begin
                errors++; $display("FAIL rnd_epcout[%0d]: got %h expected %h", i, EPCOut, m_epcout());
            end
            checks++;
            if (DOut !== m_read(A1)) begin
                errors++; $display("FAIL rnd_dout[%0d] a=%0d: got %h expected %h", i, A1, DOut, m_read(A1));
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
        test_reset();
        test_interrupt();
        test_exception_bd();
        test_exl_mask();
        test_epc_forward();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
